srl_delay_line: RTL and testbench

//  Parametrised shift-register delay line, WIDTH bits wide and DEPTH stages deep.
//  Has a dynamic tap address (Q) and a cascade output of the last stage (Q_LAST).

---
 rtl/srl_delay_line_if.sv | 27 ++
 rtl/srl_delay_line.sv | 93 +++++++++
 tb/tb_srl_delay_line.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/srl_delay_line_if.sv
// Tap/shift bus for srl_delay_line: shift controls and data in, tap/cascade/fill out.
// The master side drives shift controls; the delay line drives the tap results.
interface srl_delay_line_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic              ce;
    logic              flush;
    logic [WIDTH-1:0]  d;
    logic [ADDR_W-1:0] a;
    logic [WIDTH-1:0]  q;
    logic              q_valid;
    logic [WIDTH-1:0]  q_last;
    logic [ADDR_W:0]   fill;

    modport master (
        output ce, flush, d, a,
        input  q, q_valid, q_last, fill
    );

    modport slave (
        input  ce, flush, d, a,
        output q, q_valid, q_last, fill
    );
endinterface

// File: rtl/srl_delay_line.sv
// Shift-register delay line with dynamic tap, cascade output, fill tracking and
// optional registered tap; resets and flushes to a per-stage INIT pattern.
module srl_delay_line #(
    parameter int unsigned              WIDTH   = 8,
    parameter int unsigned              DEPTH   = 16,
    parameter logic [WIDTH*DEPTH-1:0]   INIT    = '0,
    parameter bit                       REG_OUT = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    srl_delay_line_if.slave     bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned FILL_W = ADDR_W + 1;

    logic [WIDTH-1:0]  stage_q [DEPTH];
    logic [WIDTH-1:0]  stage_d [DEPTH];
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic [WIDTH-1:0]  tap_c;
    logic              tap_valid_c;

    // Storage and fill counter; reset loads INIT without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= INIT[i*WIDTH +: WIDTH];
            end
            fill_q <= '0;
        end else begin
            stage_q <= stage_d;
            fill_q  <= fill_d;
        end
    end

    // Flush has priority over shift; fill saturates at DEPTH.
    always_comb begin
        stage_d = stage_q;
        fill_d  = fill_q;
        if (bus.flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_d[i] = INIT[i*WIDTH +: WIDTH];
            end
            fill_d = '0;
        end else if (bus.ce) begin
            stage_d[0] = bus.d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
            if (fill_q < FILL_W'(DEPTH)) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    // Tap addresses beyond the last stage read as empty.
    always_comb begin
        tap_c       = '0;
        tap_valid_c = 1'b0;
        if (32'(bus.a) < DEPTH) begin
            tap_c       = stage_q[bus.a];
            tap_valid_c = (fill_q > FILL_W'(bus.a));
        end
    end

    generate
        if (REG_OUT) begin : g_reg_out
            logic [WIDTH-1:0] q_q;
            logic             q_valid_q;

            // Loads every edge, independent of ce, so tap-address changes land one cycle later.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_q       <= '0;
                    q_valid_q <= 1'b0;
                end else begin
                    q_q       <= tap_c;
                    q_valid_q <= tap_valid_c;
                end
            end

            assign bus.q       = q_q;
            assign bus.q_valid = q_valid_q;
        end else begin : g_comb_out
            assign bus.q       = tap_c;
            assign bus.q_valid = tap_valid_c;
        end
    endgenerate

    assign bus.q_last = stage_q[DEPTH-1];
    assign bus.fill   = fill_q;

endmodule

// File: tb/tb_srl_delay_line.sv
// Scoreboard bench for srl_delay_line: four instances covering zero/ramp INIT,
// a non-power-of-two depth and the registered-tap variant.
module tb_srl_delay_line;
    localparam int unsigned W   = 8;
    localparam int unsigned D16 = 16;
    localparam int unsigned D12 = 12;

    function automatic logic [W*D16-1:0] ramp16();
        logic [W*D16-1:0] r;
        r = '0;
        for (int i = 0; i < int'(D16); i++) r[i*W +: W] = W'(i);
        return r;
    endfunction

    function automatic logic [W*D12-1:0] ramp12();
        logic [W*D12-1:0] r;
        r = '0;
        for (int i = 0; i < int'(D12); i++) r[i*W +: W] = W'(8'h40 + i);
        return r;
    endfunction

    localparam logic [W*D16-1:0] INIT_B = ramp16();
    localparam logic [W*D12-1:0] INIT_C = ramp12();

    logic clk;
    logic rst_n;
    int   vecs;
    int   errs;
    logic [W-1:0] sb_a[$];
    logic [W-1:0] sb_b[$];
    logic [W-1:0] sb_c[$];

    srl_delay_line_if #(.WIDTH(W), .DEPTH(D16)) ifa();
    srl_delay_line_if #(.WIDTH(W), .DEPTH(D16)) ifb();
    srl_delay_line_if #(.WIDTH(W), .DEPTH(D12)) ifc();
    srl_delay_line_if #(.WIDTH(W), .DEPTH(D16)) ifd();

    srl_delay_line #(.WIDTH(W), .DEPTH(D16), .INIT('0), .REG_OUT(1'b0))
        u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    srl_delay_line #(.WIDTH(W), .DEPTH(D16), .INIT(INIT_B), .REG_OUT(1'b0))
        u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    srl_delay_line #(.WIDTH(W), .DEPTH(D12), .INIT(INIT_C), .REG_OUT(1'b0))
        u_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));
    srl_delay_line #(.WIDTH(W), .DEPTH(D16), .INIT('0), .REG_OUT(1'b1))
        u_d (.clk(clk), .rst_n(rst_n), .bus(ifd.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        ifa.ce = 0; ifa.flush = 0; ifa.d = '0; ifa.a = '0;
        ifb.ce = 0; ifb.flush = 0; ifb.d = '0; ifb.a = 4'd5;
        ifc.ce = 0; ifc.flush = 0; ifc.d = '0; ifc.a = '0;
        ifd.ce = 0; ifd.flush = 0; ifd.d = '0; ifd.a = '0;
        #1 rst_n = 1'b0;
        #2;
        vecs++; if (ifa.fill !== 5'd0) begin errs++; $display("FAIL reset_fill_a got=%0d exp=0", ifa.fill); end
        vecs++; if (ifa.q_valid !== 1'b0) begin errs++; $display("FAIL reset_qv_a got=%b exp=0", ifa.q_valid); end
        vecs++; if (ifa.q !== 8'd0) begin errs++; $display("FAIL reset_q_a got=%0h exp=0", ifa.q); end
        vecs++; if (ifb.q !== 8'd5) begin errs++; $display("FAIL reset_q_b got=%0h exp=5", ifb.q); end
        vecs++; if (ifb.q_last !== 8'd15) begin errs++; $display("FAIL reset_qlast_b got=%0h exp=f", ifb.q_last); end
        vecs++; if (ifd.q !== 8'd0 || ifd.q_valid !== 1'b0) begin errs++; $display("FAIL reset_regout_d got=%0h/%b exp=0/0", ifd.q, ifd.q_valid); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_init_sweep();
        for (int a = 0; a < int'(D16); a++) begin
            ifb.a = 4'(a);
            #1;
            vecs++; if (ifb.q !== 8'(a) || ifb.q_valid !== 1'b0) begin
                errs++; $display("FAIL init_sweep a=%0d got=%0h/%b exp=%0h/0", a, ifb.q, ifb.q_valid, a);
            end
            vecs++; if (ifb.q_last !== 8'd15) begin errs++; $display("FAIL init_qlast got=%0h exp=f", ifb.q_last); end
        end
        vecs++; if (ifb.fill !== 5'd0) begin errs++; $display("FAIL init_fill got=%0d exp=0", ifb.fill); end
    endtask

    task automatic test_stream();
        logic [W-1:0] exp_q, exp_last, prev_q;
        logic         exp_v, prev_v;
        int           exp_fill;
        sb_a.delete();
        ifa.a = 4'd3; ifd.a = 4'd3;
        prev_q = '0; prev_v = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            ifa.ce = 1'b1; ifa.d = W'(n);
            ifd.ce = 1'b1; ifd.d = W'(n);
            sb_a.push_back(W'(n));
            if (sb_a.size() > D16) void'(sb_a.pop_front());
            tick();
            exp_fill = (n > 16) ? 16 : n;
            exp_v    = (n > 3);
            exp_q    = exp_v ? sb_a[sb_a.size()-4] : 8'd0;
            exp_last = (sb_a.size() == D16) ? sb_a[0] : 8'd0;
            vecs++; if (ifa.q !== exp_q || ifa.q_valid !== exp_v) begin
                errs++; $display("FAIL stream_tap n=%0d got=%0h/%b exp=%0h/%b", n, ifa.q, ifa.q_valid, exp_q, exp_v);
            end
            vecs++; if (ifa.fill !== 5'(exp_fill)) begin
                errs++; $display("FAIL stream_fill n=%0d got=%0d exp=%0d", n, ifa.fill, exp_fill);
            end
            vecs++; if (ifa.q_last !== exp_last) begin
                errs++; $display("FAIL stream_qlast n=%0d got=%0h exp=%0h", n, ifa.q_last, exp_last);
            end
            vecs++; if (ifd.q !== prev_q || ifd.q_valid !== prev_v) begin
                errs++; $display("FAIL regout_lag n=%0d got=%0h/%b exp=%0h/%b", n, ifd.q, ifd.q_valid, prev_q, prev_v);
            end
            vecs++; if (ifd.fill !== 5'(exp_fill)) begin
                errs++; $display("FAIL regout_fill n=%0d got=%0d exp=%0d", n, ifd.fill, exp_fill);
            end
            prev_q = exp_q; prev_v = exp_v;
        end
        ifa.ce = 1'b0; ifd.ce = 1'b0;
    endtask

    task automatic test_retap();
        logic [W-1:0] exp5, exp2;
        exp5 = sb_a[sb_a.size()-6];
        exp2 = sb_a[sb_a.size()-3];
        ifd.a = 4'd5;
        tick();
        vecs++; if (ifd.q !== exp5 || ifd.q_valid !== 1'b1) begin
            errs++; $display("FAIL retap_a5 got=%0h/%b exp=%0h/1", ifd.q, ifd.q_valid, exp5);
        end
        ifd.a = 4'd2;
        #1;
        vecs++; if (ifd.q !== exp5) begin errs++; $display("FAIL retap_hold got=%0h exp=%0h", ifd.q, exp5); end
        tick();
        vecs++; if (ifd.q !== exp2 || ifd.q_valid !== 1'b1) begin
            errs++; $display("FAIL retap_a2 got=%0h/%b exp=%0h/1", ifd.q, ifd.q_valid, exp2);
        end
    endtask

    task automatic test_flush();
        sb_b.delete();
        ifb.a = 4'd0;
        for (int n = 1; n <= 20; n++) begin
            ifb.ce = 1'b1; ifb.d = W'(8'h80 + n);
            sb_b.push_back(W'(8'h80 + n));
            tick();
            vecs++; if (ifb.q !== sb_b[sb_b.size()-1] || ifb.q_valid !== 1'b1) begin
                errs++; $display("FAIL flush_pre n=%0d got=%0h/%b exp=%0h/1", n, ifb.q, ifb.q_valid, sb_b[sb_b.size()-1]);
            end
        end
        ifb.flush = 1'b1; ifb.ce = 1'b1; ifb.d = 8'hAA;
        ifd.flush = 1'b1; ifd.ce = 1'b1; ifd.d = 8'hAA;
        tick();
        ifb.flush = 1'b0; ifb.ce = 1'b0;
        ifd.flush = 1'b0; ifd.ce = 1'b0;
        sb_b.delete();
        vecs++; if (ifb.fill !== 5'd0 || ifb.q_valid !== 1'b0) begin
            errs++; $display("FAIL flush_state got=%0d/%b exp=0/0", ifb.fill, ifb.q_valid);
        end
        vecs++; if (ifb.q !== 8'd0 || ifb.q_last !== 8'd15) begin
            errs++; $display("FAIL flush_init got=%0h/%0h exp=0/f", ifb.q, ifb.q_last);
        end
        vecs++; if (ifd.q !== 8'd18 || ifd.q_valid !== 1'b1) begin
            errs++; $display("FAIL flush_regout_hold got=%0h/%b exp=12/1", ifd.q, ifd.q_valid);
        end
        ifb.ce = 1'b1; ifb.d = 8'h55;
        sb_b.push_back(8'h55);
        tick();
        ifb.ce = 1'b0;
        vecs++; if (ifb.fill !== 5'd1 || ifb.q !== sb_b[0] || ifb.q_valid !== 1'b1) begin
            errs++; $display("FAIL flush_next got=%0d/%0h/%b exp=1/%0h/1", ifb.fill, ifb.q, ifb.q_valid, sb_b[0]);
        end
        vecs++; if (ifd.q !== 8'd0 || ifd.q_valid !== 1'b0) begin
            errs++; $display("FAIL flush_regout_post got=%0h/%b exp=0/0", ifd.q, ifd.q_valid);
        end
        ifb.a = 4'd1;
        #1;
        vecs++; if (ifb.q !== 8'd0 || ifb.q_valid !== 1'b0) begin
            errs++; $display("FAIL flush_stage1 got=%0h/%b exp=0/0", ifb.q, ifb.q_valid);
        end
    endtask

    task automatic test_depth12();
        logic [W-1:0] exp_q;
        logic         exp_v;
        for (int a = 12; a < 16; a++) begin
            ifc.a = 4'(a);
            #1;
            vecs++; if (ifc.q !== 8'd0 || ifc.q_valid !== 1'b0) begin
                errs++; $display("FAIL d12_oob a=%0d got=%0h/%b exp=0/0", a, ifc.q, ifc.q_valid);
            end
        end
        sb_c.delete();
        ifc.a = 4'd11;
        for (int n = 1; n <= 12; n++) begin
            ifc.ce = 1'b1; ifc.d = W'(8'h10 + n);
            sb_c.push_back(W'(8'h10 + n));
            tick();
            exp_v = (n >= 12);
            exp_q = exp_v ? sb_c[0] : W'(8'h40 + 11 - n);
            vecs++; if (ifc.q !== exp_q || ifc.q_valid !== exp_v || ifc.q_last !== exp_q) begin
                errs++; $display("FAIL d12_last n=%0d got=%0h/%b/%0h exp=%0h/%b/%0h", n, ifc.q, ifc.q_valid, ifc.q_last, exp_q, exp_v, exp_q);
            end
        end
        ifc.ce = 1'b0;
        vecs++; if (ifc.fill !== 5'd12) begin errs++; $display("FAIL d12_fill got=%0d exp=12", ifc.fill); end
        ifc.a = 4'd12;
        #1;
        vecs++; if (ifc.q !== 8'd0 || ifc.q_valid !== 1'b0) begin
            errs++; $display("FAIL d12_oob_full got=%0h/%b exp=0/0", ifc.q, ifc.q_valid);
        end
    endtask

    task automatic test_async_reset();
        ifa.a = 4'd3; ifb.a = 4'd3;
        ifa.ce = 1'b1; ifb.ce = 1'b1; ifa.d = 8'h77; ifb.d = 8'h66;
        tick();
        tick();
        ifa.ce = 1'b0; ifb.ce = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vecs++; if (ifa.fill !== 5'd0 || ifa.q_valid !== 1'b0 || ifa.q !== 8'd0) begin
            errs++; $display("FAIL arst_a got=%0d/%b/%0h exp=0/0/0", ifa.fill, ifa.q_valid, ifa.q);
        end
        vecs++; if (ifb.q !== 8'd3 || ifb.q_last !== 8'd15 || ifb.fill !== 5'd0) begin
            errs++; $display("FAIL arst_b got=%0h/%0h/%0d exp=3/f/0", ifb.q, ifb.q_last, ifb.fill);
        end
        vecs++; if (ifc.fill !== 5'd0 || ifd.q !== 8'd0 || ifd.q_valid !== 1'b0) begin
            errs++; $display("FAIL arst_cd got=%0d/%0h/%b exp=0/0/0", ifc.fill, ifd.q, ifd.q_valid);
        end
        #1 rst_n = 1'b1;
        tick();
        vecs++; if (ifb.fill !== 5'd0 || ifb.q !== 8'd3) begin
            errs++; $display("FAIL arst_after got=%0d/%0h exp=0/3", ifb.fill, ifb.q);
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_init_sweep();
        test_stream();
        test_retap();
        test_flush();
        test_depth12();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached vecs=%0d", vecs);
        $fatal(1);
    end
endmodule
